// File: rtl/branch_pred_port_sched.sv
// branch_pred_port_sched: shares the single predictor-table port between IF lookups, queued training updates and the post-reset init sweep
module branch_pred_port_sched #(
    parameter int IDX_W  = 6,
    parameter int QDEPTH = 4,
    parameter int GHR_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [31:0]               pc,
    input  logic [6:0]                opcode,
    input  logic [31:0]               ex_mem_pc,
    input  logic [6:0]                ex_mem_opcode,
    input  logic                      ex_mem_br_en,
    input  logic                      ex_mem_lc_dir,
    input  logic                      ex_mem_gl_dir,
    output logic                      lookup_ready,
    output logic                      tbl_en,
    output logic                      tbl_we,
    output logic                      tbl_init,
    output logic [IDX_W-1:0]          tbl_idx,
    output logic                      tbl_taken,
    output logic                      tbl_lc_ok,
    output logic                      tbl_gl_ok,
    output logic                      tbl_sel_upd,
    output logic [GHR_W-1:0]          ghr,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      init_done
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [6:0] BR_OP = 7'b1100011;

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic             lc_ok;
        logic             gl_ok;
        logic             sel_upd;
    } entry_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    entry_t           mem_q [QDEPTH];
    entry_t           mem_d [QDEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             done_q;
    logic             in_init, in_run, full, empty, lk_req, lk_gnt, push, pop;
    entry_t           head, new_e;
    logic             unused_pc_bits;

    // Only the index bits of the PCs matter to the tables.
    assign unused_pc_bits = ^{pc[31:IDX_W+2], pc[1:0], ex_mem_pc[31:IDX_W+2], ex_mem_pc[1:0]};

    // Decode requests and arbitrate: a full queue forces a drain, otherwise lookups win over draining.
    always_comb begin
        in_init = rst && (state_q == S_INIT);
        in_run  = rst && (state_q == S_RUN);
        full    = cnt_q == (PW+1)'(QDEPTH);
        empty   = cnt_q == '0;
        lk_req  = in_run && (opcode == BR_OP) && !stall;
        push    = in_run && (ex_mem_opcode == BR_OP) && !stall;
        pop     = in_run && (full || (!lk_req && !empty));
        lk_gnt  = lk_req && !full;
        head    = mem_q[rd_q];
        new_e   = '{idx:     ex_mem_pc[IDX_W+1:2],
                    taken:   ex_mem_br_en,
                    lc_ok:   ex_mem_lc_dir == ex_mem_br_en,
                    gl_ok:   ex_mem_gl_dir == ex_mem_br_en,
                    sel_upd: ex_mem_lc_dir != ex_mem_gl_dir};
    end

    // Drive the table port from whichever requester holds the grant; everything is quiet in reset.
    always_comb begin
        lookup_ready = lk_gnt;
        tbl_en       = in_init || lk_gnt || pop;
        tbl_we       = in_init || pop;
        tbl_init     = in_init;
        tbl_idx      = in_init ? init_cnt_q : pop ? head.idx : lk_gnt ? pc[IDX_W+1:2] : '0;
        tbl_taken    = pop && head.taken;
        tbl_lc_ok    = pop && head.lc_ok;
        tbl_gl_ok    = pop && head.gl_ok;
        tbl_sel_upd  = pop && head.sel_upd;
    end

    // Next-state: sweep counter, FIFO pointers/occupancy/storage and history shift on each drain.
    always_comb begin
        state_d    = (state_q == S_INIT && &init_cnt_q) ? S_RUN : state_q;
        init_cnt_d = (state_q == S_INIT) ? init_cnt_q + 1'b1 : init_cnt_q;
        rd_d       = rd_q + PW'(pop);
        wr_d       = wr_q + PW'(push);
        cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        ghr_d      = pop ? {ghr_q[GHR_W-2:0], head.taken} : ghr_q;
        mem_d      = mem_q;
        if (push) mem_d[wr_q] = new_e;
    end

    // Control state with synchronous active-low reset; queued updates are discarded on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            ghr_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            ghr_q      <= ghr_d;
            done_q     <= state_d == S_RUN;
        end
    end

    // FIFO payload needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ghr       = ghr_q;
    assign q_count   = cnt_q;
    assign init_done = done_q;
endmodule

// File: tb/tb_branch_pred_port_sched.sv
// tb_branch_pred_port_sched: random and directed stimulus checked against a queue-based model of the port scheduler
module tb_branch_pred_port_sched;
    localparam logic [6:0] BR = 7'h63;
    localparam logic [6:0] NB = 7'h13;

    logic        clk, rst, stall, ex_mem_br_en, ex_mem_lc_dir, ex_mem_gl_dir;
    logic [31:0] pc, ex_mem_pc;
    logic [6:0]  opcode, ex_mem_opcode;
    logic        lookup_ready, tbl_en, tbl_we, tbl_init, tbl_taken, tbl_lc_ok, tbl_gl_ok, tbl_sel_upd, init_done;
    logic [5:0]  tbl_idx, ghr;
    logic [2:0]  q_count;

    branch_pred_port_sched dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc), .opcode(opcode),
        .ex_mem_pc(ex_mem_pc), .ex_mem_opcode(ex_mem_opcode), .ex_mem_br_en(ex_mem_br_en),
        .ex_mem_lc_dir(ex_mem_lc_dir), .ex_mem_gl_dir(ex_mem_gl_dir),
        .lookup_ready(lookup_ready), .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_init(tbl_init),
        .tbl_idx(tbl_idx), .tbl_taken(tbl_taken), .tbl_lc_ok(tbl_lc_ok), .tbl_gl_ok(tbl_gl_ok),
        .tbl_sel_upd(tbl_sel_upd), .ghr(ghr), .q_count(q_count), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] idx;
        bit tk, lo, go, su;
    } ent_t;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         m_init = 1'b1;
    int         m_cnt = 0;
    ent_t       m_q[$];
    logic [5:0] m_ghr = '0;
    bit         m_done = 1'b0;
    logic       o_lr, o_we, o_tk, o_lo, o_go, o_su;
    logic [5:0] o_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check the port against the model, then advance the model across the edge.
    task automatic step(input bit r, input bit st, input logic [6:0] op, input logic [31:0] p,
                        input logic [6:0] eop, input logic [31:0] ep, input bit b, input bit lc, input bit gl);
        bit         lr, en, we, ini, tk, lo, go, su, drain;
        logic [5:0] idx;
        ent_t       h;
        @(negedge clk);
        rst = r; stall = st; opcode = op; pc = p;
        ex_mem_opcode = eop; ex_mem_pc = ep; ex_mem_br_en = b; ex_mem_lc_dir = lc; ex_mem_gl_dir = gl;
        #1;
        {lr, en, we, ini, tk, lo, go, su, drain} = '0;
        idx = '0;
        if (r && m_init) begin
            {en, we, ini} = 3'b111;
            idx = 6'(m_cnt);
        end else if (r) begin
            if (m_q.size() == 4) drain = 1'b1;
            else if (op == BR && !st) begin
                {lr, en} = 2'b11;
                idx = p[7:2];
            end else if (m_q.size() > 0) drain = 1'b1;
            if (drain) begin
                {en, we} = 2'b11;
                idx = m_q[0].idx;
                {tk, lo, go, su} = {m_q[0].tk, m_q[0].lo, m_q[0].go, m_q[0].su};
            end
        end
        {o_lr, o_we, o_idx, o_tk, o_lo, o_go, o_su} = {lookup_ready, tbl_we, tbl_idx, tbl_taken, tbl_lc_ok, tbl_gl_ok, tbl_sel_upd};
        check("port", {17'd0, lookup_ready, tbl_en, tbl_we, tbl_init, tbl_idx, tbl_taken, tbl_lc_ok, tbl_gl_ok, tbl_sel_upd},
                      {17'd0, lr, en, we, ini, idx, tk, lo, go, su});
        @(posedge clk);
        if (!r) begin
            m_init = 1'b1; m_cnt = 0; m_q.delete(); m_ghr = '0; m_done = 1'b0;
        end else if (m_init) begin
            m_cnt++;
            if (m_cnt == 64) begin
                m_init = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (drain) begin
                h = m_q.pop_front();
                m_ghr = {m_ghr[4:0], h.tk};
            end
            if (eop == BR && !st) m_q.push_back('{ep[7:2], b, lc == b, gl == b, lc != gl});
        end
        #1;
        check("regs", {22'd0, ghr, q_count, init_done}, {22'd0, m_ghr, 3'(m_q.size()), m_done});
    endtask

    task automatic idle();
        step(1, 0, NB, 32'h0, NB, 32'h0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; pc = '0; opcode = NB; ex_mem_pc = '0; ex_mem_opcode = NB;
        ex_mem_br_en = 1'b0; ex_mem_lc_dir = 1'b0; ex_mem_gl_dir = 1'b0;
        // Reset two cycles, then the 64-entry sweep with EX/MEM branches that must be discarded.
        repeat (2) step(0, 0, BR, 32'h4, BR, 32'h8, 1, 1, 0);
        check("rst_done", init_done, 0);
        for (int i = 0; i < 64; i++) begin
            step(1, 0, BR, 32'h104, BR, 32'h10, 1, 0, 1);
            check("init_idx", o_idx, i);
            check("init_lr", o_lr, 0);
        end
        check("init_done", init_done, 1);
        check("init_q", q_count, 0);
        // Lookup only.
        step(1, 0, BR, 32'h0000_0104, NB, 32'h0, 0, 0, 0);
        check("lk_ready", o_lr, 1);
        check("lk_idx", o_idx, 1);
        // Single update then drain.
        step(1, 0, NB, 32'h0, BR, 32'h0000_0010, 1, 0, 1);
        idle();
        check("drain_fields", {o_we, o_idx, o_tk, o_lo, o_go, o_su}, {1'b1, 6'd4, 4'b1011});
        check("drain_ghr", ghr, 6'b000001);
        check("drain_q", q_count, 0);
        // Back-pressure: four lookups with enqueues, then a fifth enqueue while full.
        for (int i = 0; i < 4; i++) step(1, 0, BR, 32'h200 + i * 4, BR, 32'h40 + i * 4, i[0], 1, i[1]);
        check("full_q", q_count, 4);
        step(1, 0, BR, 32'h300, BR, 32'h80, 1, 1, 1);
        check("full_lr", o_lr, 0);
        check("full_hold", q_count, 4);
        repeat (4) idle();
        check("full_empty", q_count, 0);
        // Stall: two queued, then stalled branches on both sides.
        repeat (2) step(1, 0, BR, 32'h20, BR, 32'h24, 1, 0, 0);
        check("stall_pre", q_count, 2);
        step(1, 1, BR, 32'h20, BR, 32'h28, 1, 1, 1);
        check("stall_lr", o_lr, 0);
        check("stall_q1", q_count, 1);
        step(1, 1, BR, 32'h20, BR, 32'h28, 1, 1, 1);
        check("stall_q0", q_count, 0);
        // Build ghr = 101101 then three queued entries, then a one-cycle reset.
        for (int i = 0; i < 7; i++) begin
            logic [6:0] pat;
            pat = 7'b1011010;
            step(1, 0, NB, 32'h0, BR, 32'h30, pat[6 - i], 0, 1);
        end
        repeat (2) step(1, 0, BR, 32'h50, BR, 32'h34, 0, 0, 0);
        check("pre_ghr", ghr, 6'b101101);
        check("pre_q", q_count, 3);
        step(0, 0, BR, 32'h50, BR, 32'h34, 1, 1, 1);
        check("mrst", {ghr, q_count, init_done}, 0);
        step(1, 0, BR, 32'h50, NB, 32'h0, 0, 0, 0);
        check("mrst_idx", {o_we, o_idx}, {1'b1, 6'd0});
        // Random traffic, including occasional resets.
        repeat (3000)
            step(($urandom % 400) != 0, ($urandom % 5) == 0,
                 ($urandom % 2) ? BR : NB, $urandom, ($urandom % 3) ? BR : NB, $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_pred_port_sched.md
Name: branch_pred_port_sched

Overview:
- Scheduler for the single-ported branch-predictor table array (local PHT, global PHT, chooser), sharing one port between IF-stage lookups and EX/MEM-stage training updates.
- After reset, sweeps every table index to the weakly-not-taken init value.
- Buffers resolved-branch updates in a small FIFO and maintains the committed global history register (GHR).
- Sits between the fetch/EX-MEM pipeline signals and the predictor table RAMs.

Parameters:
- IDX_W, 6, table index width; tables hold 2^IDX_W entries.
- QDEPTH, 4, update FIFO depth (power of 2, at least 2).
- GHR_W, 6, global history length.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- stall  in  1  pipeline stall; suppresses lookup and enqueue.
- pc  in  32  IF-stage PC.
- opcode  in  7  IF-stage opcode.
- ex_mem_pc  in  32  PC of resolving instruction.
- ex_mem_opcode  in  7  opcode of resolving instruction.
- ex_mem_br_en  in  1  actual branch outcome (1 = taken).
- ex_mem_lc_dir  in  1  local prediction made for this branch.
- ex_mem_gl_dir  in  1  global prediction made for this branch.
- lookup_ready  out  1  table port granted to lookup this cycle.
- tbl_en  out  1  table port access enable.
- tbl_we  out  1  write (update or init) this cycle.
- tbl_init  out  1  write is an init-sweep write.
- tbl_idx  out  IDX_W  table index.
- tbl_taken  out  1  update outcome.
- tbl_lc_ok  out  1  local prediction was correct.
- tbl_gl_ok  out  1  global prediction was correct.
- tbl_sel_upd  out  1  chooser update enable (lc_dir != gl_dir).
- ghr  out  GHR_W  committed global history; LSB is newest.
- q_count  out  clog2(QDEPTH)+1  FIFO occupancy.
- init_done  out  1  sweep complete.

Behaviour:
- Branch definition: opcode == 7'b1100011. Index = pc[IDX_W+1:2]; update index uses ex_mem_pc[IDX_W+1:2].
- Reset (rst == 0 at posedge):
  - state = INIT, init_cnt = 0, FIFO emptied, ghr = 0, q_count = 0, init_done = 0.
  - While rst == 0, all table outputs and lookup_ready are 0.
- INIT state:
  - Each cycle: tbl_en = tbl_we = tbl_init = 1, tbl_idx = init_cnt; init_cnt increments.
  - After the write at index 2^IDX_W-1, go to RUN.
  - init_done is registered and becomes 1 in the first RUN cycle.
  - In INIT, lookup_ready = 0 and EX/MEM updates are discarded (not enqueued).
- RUN state, enqueue:
  - Condition: ex_mem_opcode is a branch and stall == 0.
  - Pushes {idx, br_en, lc_ok = (lc_dir == br_en), gl_ok = (gl_dir == br_en), sel_upd = (lc_dir != gl_dir)}.
  - An entry is visible at the FIFO head the next cycle (no same-cycle bypass).
- RUN state, lookup request: opcode is a branch and stall == 0.
- Port arbitration (combinational, one grant per cycle):
  - FIFO full: drain head. lookup_ready = 0.
  - Else if lookup request: tbl_en = 1, tbl_we = 0, tbl_idx = lookup index, lookup_ready = 1.
  - Else if FIFO non-empty: drain head; tbl_we = 1, tbl_init = 0, remaining fields from head.
  - Else: tbl_en = 0, lookup_ready = 0.
- Drain commit: on the drain edge, pop the head and set ghr <= {ghr[GHR_W-2:0], head.taken}.
- Full FIFO:
  - Drain is forced, so a same-cycle enqueue and pop are legal and q_count is unchanged.
  - Updates are never dropped.
- Simultaneous push and pop at non-full, non-empty occupancy: q_count unchanged; FIFO order preserved. Pointers wrap modulo QDEPTH.
- stall == 1: no lookup and no enqueue, but draining continues.
- Reset asserted mid-INIT or mid-RUN: takes effect at the next posedge per the reset rules above; queued updates are lost.
- Registered: state, init_cnt, FIFO, ghr, q_count, init_done. Table-port outputs are combinational from state, FIFO head and inputs.

Test Plan:
- Init sweep: rst = 0 for 2 cycles, then 1 (IDX_W = 6). Required: tbl_we = tbl_init = 1 with tbl_idx 0..63 on 64 consecutive cycles; init_done = 1 on cycle 64; lookup_ready = 0 throughout.
- Lookup only: in RUN, opcode = 7'h63, pc = 32'h0000_0104, stall = 0, FIFO empty. Required: lookup_ready = 1, tbl_en = 1, tbl_we = 0, tbl_idx = 6'd1 (pc[7:2]), same cycle.
- Update drain with no lookup:
  - Stimulus: one EX/MEM branch, ex_mem_pc = 32'h0000_0010, br_en = 1, lc_dir = 0, gl_dir = 1.
  - Required next cycle: tbl_we = 1, tbl_idx = 4, tbl_taken = 1, tbl_lc_ok = 0, tbl_gl_ok = 1, tbl_sel_upd = 1.
  - Required after the drain edge: ghr = 6'b000001, q_count = 0.
- Full-queue back-pressure:
  - Stimulus: lookups every cycle while 4 updates enqueue, then a 5th update arrives while full.
  - Required: q_count reaches 4; lookup_ready drops to 0; head drains while the 5th entry enters; q_count stays 4; no entry lost, checked by matching drain order against enqueue order.
- Stall: stall = 1 with branch opcodes on both IF and EX/MEM and 2 entries queued. Required: no enqueue, lookup_ready = 0, both entries drain on consecutive cycles, q_count goes 2 → 1 → 0.
- Mid-run reset: rst = 0 for 1 cycle with 3 entries queued and ghr = 6'b101101. Required: q_count = 0, ghr = 0, init_done = 0; the INIT sweep restarts at index 0.
